// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: operand forwarding, load-use stall/bubble, taken-branch
// flush and multi-cycle EX freeze for a 5-stage pipeline.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   RS_2 / RS_3            source register indices in ID / EX (5 bits per source)
//   ALU_Src_3              EX uses immediate as operand B (source 1)
//   RD_3, Mem_Read_3       EX destination, EX is a load
//   RD_4/Reg_Write_4       MEM destination and write enable
//   RD_5/Reg_Write_5       WB destination and write enable
//   MC_Start_3             multi-cycle op enters EX
//   Branch_Taken_3         branch resolved taken in EX
//   Sel, Store_Sel         operand / store-data forward selects
//   Stall_1/2/3            hold PC / IF-ID / ID-EX+EX
//   Flush_2/3              zero IF-ID / bubble into ID-EX
//   Busy, Mc_Done          multi-cycle op in progress / final wait cycle
//
// Optional: define HAZ_PERF_EN to add saturating Lu_Stall_Cnt, Mc_Stall_Cnt
// and Flush_Cnt event counters of width CNT_W.
//
// Hazard outputs are combinational from the current inputs and FSM state and
// are forced inactive while rst_n is low.
module hazard_forward_ctrl #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned MC_LAT  = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5*NUM_SRC-1:0]   RS_2,
  input  logic [5*NUM_SRC-1:0]   RS_3,
  input  logic                   ALU_Src_3,
  input  logic [4:0]             RD_3,
  input  logic                   Mem_Read_3,
  input  logic [4:0]             RD_4,
  input  logic                   Reg_Write_4,
  input  logic [4:0]             RD_5,
  input  logic                   Reg_Write_5,
  input  logic                   MC_Start_3,
  input  logic                   Branch_Taken_3,
  output logic [2*NUM_SRC-1:0]   Sel,
  output logic [1:0]             Store_Sel,
  output logic                   Stall_1,
  output logic                   Stall_2,
  output logic                   Stall_3,
  output logic                   Flush_2,
  output logic                   Flush_3,
  output logic                   Busy,
  output logic                   Mc_Done
`ifdef HAZ_PERF_EN
  ,
  output logic [CNT_W-1:0]       Lu_Stall_Cnt,
  output logic [CNT_W-1:0]       Mc_Stall_Cnt,
  output logic [CNT_W-1:0]       Flush_Cnt
`endif
);

  localparam int unsigned CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

  // Elaboration-time parameter checks
  if (MC_LAT < 2) begin : g_bad_mc_lat
    $error("hazard_forward_ctrl: MC_LAT must be >= 2");
  end
  if (NUM_SRC < 2) begin : g_bad_num_src
    $error("hazard_forward_ctrl: NUM_SRC must be >= 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_forward_ctrl: CNT_W must be >= 1");
  end

  typedef enum logic {RUN, MC_WAIT} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [2*NUM_SRC-1:0]  sel_c;
  logic [1:0]            store_c;
  logic                  lu_c;
  logic                  stall_fe, stall_ex, flush2, flush3, busy, mc_done;
  logic                  lu_ev, br_ev, ex_stall;

  // Forward selects (MEM over WB) and load-use detection
  always_comb begin
    sel_c   = '0;
    store_c = 2'b00;
    lu_c    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (Reg_Write_4 && RD_4 != 5'd0 && RD_4 == RS_3[5*i +: 5])
        sel_c[2*i +: 2] = 2'b01;
      else if (Reg_Write_5 && RD_5 != 5'd0 && RD_5 == RS_3[5*i +: 5])
        sel_c[2*i +: 2] = 2'b10;
      if (Mem_Read_3 && RD_3 != 5'd0 && RD_3 == RS_2[5*i +: 5])
        lu_c = 1'b1;
    end
    // Store data always takes rs2's forward, even when the ALU uses the immediate
    store_c = sel_c[3:2];
    if (ALU_Src_3)
      sel_c[3:2] = 2'b11;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FSM next state and hazard controls
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_fe  = 1'b0;
    stall_ex  = 1'b0;
    flush2    = 1'b0;
    flush3    = 1'b0;
    busy      = 1'b0;
    mc_done   = 1'b0;
    lu_ev     = 1'b0;
    br_ev     = 1'b0;
    case (state)
      RUN: begin
        if (Branch_Taken_3) begin
          flush2 = 1'b1;
          flush3 = 1'b1;
          br_ev  = 1'b1;
        end else if (lu_c) begin
          stall_fe = 1'b1;
          flush3   = 1'b1;
          lu_ev    = 1'b1;
        end
        // The EX op is older than the branch, so it starts regardless
        if (MC_Start_3) begin
          stall_fe  = 1'b1;
          stall_ex  = 1'b1;
          state_nxt = MC_WAIT;
          cnt_nxt   = CW'(MC_LAT - 2);
        end
      end
      MC_WAIT: begin
        busy = 1'b1;
        if (cnt != '0) begin
          stall_fe = 1'b1;
          stall_ex = 1'b1;
          cnt_nxt  = cnt - CW'(1);
        end else begin
          mc_done   = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // A bubble into ID/EX wins over holding it
  assign ex_stall  = stall_ex & ~flush3;

  assign Sel       = rst_n ? sel_c : '0;
  assign Store_Sel = rst_n ? store_c : 2'b00;
  assign Stall_1   = rst_n & stall_fe;
  assign Stall_2   = rst_n & stall_fe;
  assign Stall_3   = rst_n & ex_stall;
  assign Flush_2   = rst_n & flush2;
  assign Flush_3   = rst_n & flush3;
  assign Busy      = rst_n & busy;
  assign Mc_Done   = rst_n & mc_done;

`ifdef HAZ_PERF_EN
  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Lu_Stall_Cnt <= '0;
      Mc_Stall_Cnt <= '0;
      Flush_Cnt    <= '0;
    end else begin
      if (lu_ev && Lu_Stall_Cnt != '1)
        Lu_Stall_Cnt <= Lu_Stall_Cnt + CNT_W'(1);
      if (ex_stall && Mc_Stall_Cnt != '1)
        Mc_Stall_Cnt <= Mc_Stall_Cnt + CNT_W'(1);
      if (br_ev && Flush_Cnt != '1)
        Flush_Cnt <= Flush_Cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Testbench for hazard_forward_ctrl: directed cases plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_hazard_forward_ctrl;

  localparam int unsigned NUM_SRC  = 2;
  localparam int unsigned MC_LAT   = 4;
  localparam int unsigned TB_CNT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [5*NUM_SRC-1:0] RS_2, RS_3;
  logic                 ALU_Src_3, Mem_Read_3, Reg_Write_4, Reg_Write_5;
  logic [4:0]           RD_3, RD_4, RD_5;
  logic                 MC_Start_3, Branch_Taken_3;
  logic [2*NUM_SRC-1:0] Sel;
  logic [1:0]           Store_Sel;
  logic                 Stall_1, Stall_2, Stall_3, Flush_2, Flush_3, Busy, Mc_Done;
`ifdef HAZ_PERF_EN
  logic [TB_CNT_W-1:0]  Lu_Stall_Cnt, Mc_Stall_Cnt, Flush_Cnt;
`endif

  hazard_forward_ctrl #(.NUM_SRC(NUM_SRC), .MC_LAT(MC_LAT), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .RS_2(RS_2), .RS_3(RS_3), .ALU_Src_3(ALU_Src_3),
    .RD_3(RD_3), .Mem_Read_3(Mem_Read_3), .RD_4(RD_4), .Reg_Write_4(Reg_Write_4),
    .RD_5(RD_5), .Reg_Write_5(Reg_Write_5), .MC_Start_3(MC_Start_3),
    .Branch_Taken_3(Branch_Taken_3), .Sel(Sel), .Store_Sel(Store_Sel),
    .Stall_1(Stall_1), .Stall_2(Stall_2), .Stall_3(Stall_3), .Flush_2(Flush_2),
    .Flush_3(Flush_3), .Busy(Busy), .Mc_Done(Mc_Done)
`ifdef HAZ_PERF_EN
    , .Lu_Stall_Cnt(Lu_Stall_Cnt), .Mc_Stall_Cnt(Mc_Stall_Cnt), .Flush_Cnt(Flush_Cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model state: wait cycles still to come for the current multi-cycle op
  int m_left = 0;
  int m_lu = 0, m_mc = 0, m_fl = 0;
  localparam int CNT_MAX = (1 << TB_CNT_W) - 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (Reg_Write_4 && RD_4 != 0 && RD_4 == rs) return 2'b01;
    if (Reg_Write_5 && RD_5 != 0 && RD_5 == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit lu_cond();
    for (int i = 0; i < NUM_SRC; i++)
      if (Mem_Read_3 && RD_3 != 0 && RD_3 == RS_2[5*i +: 5]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int sat_inc(input int v, input bit ev);
    return (ev && v < CNT_MAX) ? v + 1 : v;
  endfunction

  // Expected-event helpers derived from the model state and current inputs
  function automatic bit e_br();    return rst_n && m_left == 0 && Branch_Taken_3; endfunction
  function automatic bit e_lu();    return rst_n && m_left == 0 && !Branch_Taken_3 && lu_cond(); endfunction
  function automatic bit e_start(); return rst_n && m_left == 0 && MC_Start_3; endfunction
  function automatic bit e_hold();  return rst_n && (e_start() || m_left > 1); endfunction

  task automatic compare_all();
    logic [2*NUM_SRC-1:0] es;
    logic [1:0]           est;
    bit                   f3;
    es  = '0;
    est = 2'b00;
    if (rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) es[2*i +: 2] = fwd(RS_3[5*i +: 5]);
      est = fwd(RS_3[9:5]);
      if (ALU_Src_3) es[3:2] = 2'b11;
    end
    f3 = e_br() || e_lu();
    check("sel",       32'(Sel),       32'(es));
    check("store_sel", 32'(Store_Sel), 32'(est));
    check("stall_1",   32'(Stall_1),   32'(e_lu() || e_hold()));
    check("stall_2",   32'(Stall_2),   32'(e_lu() || e_hold()));
    check("stall_3",   32'(Stall_3),   32'(e_hold() && !f3));
    check("flush_2",   32'(Flush_2),   32'(e_br()));
    check("flush_3",   32'(Flush_3),   32'(f3));
    check("busy",      32'(Busy),      32'(rst_n && m_left > 0));
    check("mc_done",   32'(Mc_Done),   32'(rst_n && m_left == 1));
`ifdef HAZ_PERF_EN
    check("lu_cnt",    32'(Lu_Stall_Cnt), 32'(m_lu));
    check("mc_cnt",    32'(Mc_Stall_Cnt), 32'(m_mc));
    check("flush_cnt", 32'(Flush_Cnt),    32'(m_fl));
`endif
  endtask

  task automatic model_edge();
    bit ex_st;
    if (!rst_n) begin
      m_left = 0; m_lu = 0; m_mc = 0; m_fl = 0;
    end else begin
      ex_st = e_hold() && !(e_br() || e_lu());
      m_lu = sat_inc(m_lu, e_lu());
      m_mc = sat_inc(m_mc, ex_st);
      m_fl = sat_inc(m_fl, e_br());
      if (m_left > 0) m_left--;
      else if (MC_Start_3) m_left = MC_LAT - 1;
    end
  endtask

  // Called just after a negedge with inputs set: check, clock, advance model
  task automatic tick();
    #1 compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_in();
    RS_2 = '0; RS_3 = '0; ALU_Src_3 = 0; RD_3 = 0; Mem_Read_3 = 0;
    RD_4 = 0; Reg_Write_4 = 0; RD_5 = 0; Reg_Write_5 = 0;
    MC_Start_3 = 0; Branch_Taken_3 = 0;
  endtask

  task automatic set_lu();
    clear_in();
    Mem_Read_3 = 1; RD_3 = 5'd9; RS_2[4:0] = 5'd9;
  endtask

  initial begin
    rst_n = 0;
    clear_in();
    @(negedge clk);
    #1 check("rst_stall_1", 32'(Stall_1), 0);
    check("rst_busy", 32'(Busy), 0);
    tick();
    rst_n = 1;

    // Forward priority
    RS_3 = {5'd5, 5'd5}; RD_4 = 5'd5; RD_5 = 5'd5; Reg_Write_4 = 1; Reg_Write_5 = 1;
    #1 check("fwd_mem_prio", 32'(Sel), 32'h5);
    tick();
    Reg_Write_4 = 0;
    #1 check("fwd_wb", 32'(Sel), 32'ha);
    tick();
    Reg_Write_4 = 1; RD_4 = 0; RD_5 = 0;
    #1 check("fwd_x0", 32'(Sel), 32'h0);
    tick();

    // Immediate override keeps store forward
    clear_in();
    RS_3[9:5] = 5'd7; RD_4 = 5'd7; Reg_Write_4 = 1; ALU_Src_3 = 1;
    #1 check("imm_sel1", 32'(Sel[3:2]), 32'h3);
    check("imm_store", 32'(Store_Sel), 32'h1);
    tick();

    // Load-use: one bubble, none for x0
    set_lu();
    #1 check("lu_stall", 32'({Stall_1, Stall_2, Flush_3}), 32'h7);
    tick();
    clear_in();
    #1 check("lu_gone", 32'({Stall_1, Stall_2, Flush_3}), 32'h0);
    tick();
    set_lu(); RD_3 = 0; RS_2[4:0] = 0;
    #1 check("lu_x0", 32'(Stall_1), 0);
    tick();

    // Branch outranks load-use
    set_lu(); Branch_Taken_3 = 1;
    #1 check("br_lu", 32'({Flush_2, Flush_3, Stall_1, Stall_2}), 32'hc);
    tick();

    // Multi-cycle op with MC_Start_3 held (ignored while waiting)
    clear_in(); MC_Start_3 = 1;
    #1 check("mc_start_st3", 32'({Stall_3, Busy}), 32'h2);
    tick();
    #1 check("mc_w1", 32'({Stall_3, Busy, Mc_Done}), 32'h6);
    tick();
    #1 check("mc_w2", 32'({Stall_3, Busy, Mc_Done}), 32'h6);
    tick();
    #1 check("mc_done", 32'({Stall_3, Busy, Mc_Done}), 32'h3);
    MC_Start_3 = 0;
    tick();
    #1 check("mc_after", 32'({Busy, Mc_Done}), 32'h0);
    tick();

    // Reset during MC_WAIT aborts without Mc_Done
    MC_Start_3 = 1;
    tick();
    MC_Start_3 = 0;
    tick();
    rst_n = 0;
    #1 check("rst_mid_busy", 32'({Busy, Mc_Done}), 32'h0);
    tick();
    rst_n = 1;
    #1 check("post_rst", 32'({Busy, Mc_Done, Stall_3}), 32'h0);
    tick();

`ifdef HAZ_PERF_EN
    rst_n = 0; tick(); rst_n = 1;
    for (int k = 0; k < 2; k++) begin
      set_lu(); tick(); clear_in(); tick();
    end
    MC_Start_3 = 1; tick(); MC_Start_3 = 0;
    for (int k = 0; k < MC_LAT - 1; k++) tick();
    #1 check("perf_lu2", 32'(Lu_Stall_Cnt), 2);
    check("perf_mc3", 32'(Mc_Stall_Cnt), 3);
    tick();
    set_lu();
    for (int k = 0; k < CNT_MAX + 5; k++) tick();
    #1 check("perf_sat", 32'(Lu_Stall_Cnt), 32'(CNT_MAX));
    tick();
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      for (int i = 0; i < NUM_SRC; i++) begin
        RS_2[5*i +: 5] = 5'($urandom_range(0, 3));
        RS_3[5*i +: 5] = 5'($urandom_range(0, 3));
      end
      RD_3 = 5'($urandom_range(0, 3));
      RD_4 = 5'($urandom_range(0, 3));
      RD_5 = 5'($urandom_range(0, 3));
      ALU_Src_3   = 1'($urandom_range(0, 1));
      Reg_Write_4 = 1'($urandom_range(0, 1));
      Reg_Write_5 = 1'($urandom_range(0, 1));
      MC_Start_3  = ($urandom_range(0, 11) == 0);
      Mem_Read_3  = !MC_Start_3 && ($urandom_range(0, 2) == 0);
      Branch_Taken_3 = (m_left == 0) && ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
